// File: rtl/counterdown16_1clk_negedge_reload.sv
// 16-bit falling-edge down counter used as a timer/interval generator.
// A load arms the counter; at terminal count it either reloads (periodic)
// or stops in DONE (one-shot). Each terminal count emits a one-cycle tc
// pulse and bumps a saturating event counter.
module counterdown16_1clk_negedge_reload #(
   parameter int WIDTH     = 16,
   parameter int EVT_WIDTH = 8
) (
   input  logic                 clock0,
   input  logic                 reset,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_value,
   input  logic                 enable,
   input  logic                 periodic,
   input  logic                 clear_evt,
   output logic [WIDTH-1:0]     count,
   output logic                 tc,
   output logic                 running,
   output logic                 done,
   output logic [EVT_WIDTH-1:0] evt_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] reload;
   logic             tc_event;

   // A terminal count only counts when no load pre-empts it on the same edge.
   assign tc_event = !load && (state == RUN) && enable && (count == '0);

   // Status flags are decoded straight from the registered state.
   assign running = (state == RUN);
   assign done    = (state == DONE);

   // Counter, reload register, state and tc pulse; load outranks terminal count.
   always_ff @(negedge clock0 or posedge reset) begin
      if (reset) begin
         count  <= '0;
         reload <= '0;
         state  <= IDLE;
         tc     <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (load) begin
            count  <= load_value;
            reload <= load_value;
            state  <= RUN;
         end else begin
            case (state)
               IDLE: begin
                  count <= count;
               end
               RUN: begin
                  if (enable) begin
                     if (count == '0) begin
                        tc <= 1'b1;
                        if (periodic) begin
                           count <= reload;
                        end else begin
                           // count is already zero; it simply stays there
                           state <= DONE;
                        end
                     end else begin
                        count <= count - WIDTH'(1);
                     end
                  end
               end
               DONE: begin
                  count <= '0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // Saturating terminal-count event counter; a tc coinciding with a clear is kept.
   always_ff @(negedge clock0 or posedge reset) begin
      if (reset) begin
         evt_count <= '0;
      end else if (clear_evt) begin
         evt_count <= tc_event ? EVT_WIDTH'(1) : '0;
      end else if (tc_event && (evt_count != {EVT_WIDTH{1'b1}})) begin
         evt_count <= evt_count + EVT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_counterdown16_1clk_negedge_reload.sv
// Directed bench for the falling-edge down counter. Inputs change just
// after a falling edge; outputs are sampled 1 time unit after each edge.
module tb_counterdown16_1clk_negedge_reload;

   logic        clock0;
   logic        reset;
   logic        load;
   logic [15:0] load_value;
   logic        enable;
   logic        periodic;
   logic        clear_evt;
   logic [15:0] count;
   logic        tc;
   logic        running;
   logic        done;
   logic [7:0]  evt_count;

   int checks;
   int failures;

   counterdown16_1clk_negedge_reload #(
      .WIDTH(16),
      .EVT_WIDTH(8)
   ) dut (
      .clock0     (clock0),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .periodic   (periodic),
      .clear_evt  (clear_evt),
      .count      (count),
      .tc         (tc),
      .running    (running),
      .done       (done),
      .evt_count  (evt_count)
   );

   // clock/reset block
   initial clock0 = 1'b1;
   always #5 clock0 = ~clock0;

   // single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance one active (falling) edge and settle
   task automatic step();
      @(negedge clock0);
      #1;
   endtask

   logic en_vec  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [15:0] cnt_vec [7] = '{16'd2, 16'd1, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0};
   logic tc_vec  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      load       = 1'b0;
      load_value = 16'd0;
      enable     = 1'b0;
      periodic   = 1'b0;
      clear_evt  = 1'b0;

      // reset then idle
      #12;
      check("rst_count", 32'(count), 32'd0);
      check("rst_run",   32'(running), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_tc",    32'(tc), 32'd0);
      check("rst_evt",   32'(evt_count), 32'd0);
      reset  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle_tc", 32'(tc), 32'd0);
      end
      check("idle_count", 32'(count), 32'd0);
      check("idle_run",   32'(running), 32'd0);
      check("idle_done",  32'(done), 32'd0);
      check("idle_evt",   32'(evt_count), 32'd0);

      // one-shot from 3
      periodic   = 1'b0;
      load_value = 16'd3;
      load       = 1'b1;
      step();
      load = 1'b0;
      check("os_load", 32'(count), 32'd3);
      check("os_run",  32'(running), 32'd1);
      step(); check("os_c2", 32'(count), 32'd2);
      step(); check("os_c1", 32'(count), 32'd1);
      step(); check("os_c0", 32'(count), 32'd0);
      check("os_tc_early", 32'(tc), 32'd0);
      step();
      check("os_tc",    32'(tc), 32'd1);
      check("os_done",  32'(done), 32'd1);
      check("os_run0",  32'(running), 32'd0);
      check("os_cnt",   32'(count), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         check("os_hold_tc",  32'(tc), 32'd0);
         check("os_hold_cnt", 32'(count), 32'd0);
      end
      check("os_done_hold", 32'(done), 32'd1);
      check("os_evt",       32'(evt_count), 32'd1);

      // periodic reload 2 with enable gating; evt cleared on the load edge
      periodic   = 1'b1;
      load_value = 16'd2;
      for (int i = 0; i < 7; i++) begin
         load      = (i == 0);
         clear_evt = (i == 0);
         enable    = en_vec[i];
         step();
         check("per_cnt", 32'(count), 32'(cnt_vec[i]));
         check("per_tc",  32'(tc), 32'(tc_vec[i]));
      end
      load      = 1'b0;
      clear_evt = 1'b0;
      enable    = 1'b1;
      check("per_evt", 32'(evt_count), 32'd1);
      check("per_run", 32'(running), 32'd1);

      // load collides with terminal count (count is 0, enabled, running)
      load_value = 16'd5;
      load       = 1'b1;
      step();
      check("col_cnt", 32'(count), 32'd5);
      check("col_tc",  32'(tc), 32'd0);
      check("col_evt", 32'(evt_count), 32'd1);

      // reload = 0 periodic: tc every enabled edge
      load_value = 16'd0;
      step();
      load = 1'b0;
      check("z_load_cnt", 32'(count), 32'd0);
      check("z_load_tc",  32'(tc), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("z_tc",  32'(tc), 32'd1);
         check("z_cnt", 32'(count), 32'd0);
      end
      check("z_evt", 32'(evt_count), 32'd5);

      // saturation then clear on a tc edge
      for (int i = 0; i < 300; i++) step();
      check("sat_evt", 32'(evt_count), 32'd255);
      clear_evt = 1'b1;
      step();
      clear_evt = 1'b0;
      check("clr_tc",  32'(tc), 32'd1);
      check("clr_evt", 32'(evt_count), 32'd1);
      step();
      check("clr_next_evt", 32'(evt_count), 32'd2);

      // async reset mid-run
      load_value = 16'hFFFF;
      load       = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 100; i++) step();
      check("ar_cnt", 32'(count), 32'hFF9B);
      #2;
      reset = 1'b1;
      #1;
      check("ar_cnt0", 32'(count), 32'd0);
      check("ar_run0", 32'(running), 32'd0);
      check("ar_evt0", 32'(evt_count), 32'd0);
      reset = 1'b0;
      step();
      check("ar_idle_cnt", 32'(count), 32'd0);
      check("ar_idle_run", 32'(running), 32'd0);
      periodic   = 1'b0;
      load_value = 16'd1;
      load       = 1'b1;
      step();
      load = 1'b0;
      check("ar_l1", 32'(count), 32'd1);
      step();
      check("ar_l0",  32'(count), 32'd0);
      check("ar_tc0", 32'(tc), 32'd0);
      step();
      check("ar_tc",   32'(tc), 32'd1);
      check("ar_done", 32'(done), 32'd1);
      check("ar_evt",  32'(evt_count), 32'd1);
      step();
      check("ar_tc_end", 32'(tc), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
